// File: rtl/vape_pkg.sv
// Shared constants for the executable-region exit monitor: the FSM state
// encodings and the address/count width.
package vape_pkg;

  localparam int ADDR_W = 16;

  localparam logic [ADDR_W-1:0] CNT_MAX = {ADDR_W{1'b1}};

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;
  localparam logic [1:0] ST_FAIL = 2'd3;

endpackage

// File: rtl/vape_er_exit_if.sv
// Bus between the CPU-side observation signals and the ER exit monitor.
// master: the side that supplies pc/irq/exec_in/bounds and reads results.
// slave : the monitor itself.
interface vape_er_exit_if;
  import vape_pkg::*;

  logic [ADDR_W-1:0] pc;
  logic              irq;
  logic              exec_in;
  logic [ADDR_W-1:0] ER_min;
  logic [ADDR_W-1:0] ER_max;
  logic              er_done;
  logic              er_abort;
  logic [ADDR_W-1:0] exec_cnt;

  modport master (
    output pc, irq, exec_in, ER_min, ER_max,
    input  er_done, er_abort, exec_cnt
  );

  modport slave (
    input  pc, irq, exec_in, ER_min, ER_max,
    output er_done, er_abort, exec_cnt
  );

endinterface

// File: rtl/vape_sat_cnt.sv
// Saturating up-counter with synchronous clear (clear wins over enable).
// Holds at all-ones instead of wrapping.
module vape_sat_cnt
  import vape_pkg::*;
#(
  parameter int DATA_W = ADDR_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clr,
  input  logic              en,
  output logic [DATA_W-1:0] cnt
);

  localparam logic [DATA_W-1:0] MAX_VAL = {DATA_W{1'b1}};

  // Count register: clear, else increment until it saturates.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && (cnt != MAX_VAL)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/vape_er_exit.sv
// Executable-region exit monitor. Tracks one ER run from a legal entry at
// ER_min to a legal exit at ER_max, flagging any invalidating event as an
// abort and counting the cycles spent inside the region.
// Optional feature macro: VAPE_IRQ_ABORT_EN -- when defined, an interrupt
// taken inside the region aborts the run; otherwise irq is ignored.
module vape_er_exit
  import vape_pkg::*;
(
  input  logic          clk,
  input  logic          reset_n,
  vape_er_exit_if.slave bus
);

  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic              entry_ok;
  logic              out_of_range;
  logic              irq_abort;
  logic              cnt_clr;
  logic              cnt_en;
  logic              er_done_q;
  logic              er_abort_q;
  logic [ADDR_W-1:0] cnt;

`ifdef VAPE_IRQ_ABORT_EN
  assign irq_abort = bus.irq;
`else
  // irq stays on the bus for pin compatibility but has no effect here.
  logic irq_unused;
  assign irq_unused = bus.irq;
  assign irq_abort  = 1'b0;
`endif

  // Entry legality and region bounds check (an inverted region never admits entry).
  always_comb begin
    entry_ok     = bus.exec_in && (bus.pc == bus.ER_min) && (bus.ER_min <= bus.ER_max);
    out_of_range = (bus.pc < bus.ER_min) || (bus.pc > bus.ER_max);
  end

  // Next-state decode; RUN exits are tested in priority order so that a
  // META drop always beats a simultaneous arrival at ER_max.
  always_comb begin
    state_nxt = state;
    cnt_clr   = 1'b0;
    cnt_en    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (entry_ok) begin
          state_nxt = ST_RUN;
          cnt_clr   = 1'b1;
        end
      end
      ST_RUN: begin
        cnt_en = 1'b1;
        if (!bus.exec_in) begin
          state_nxt = ST_FAIL;
        end else if (irq_abort) begin
          state_nxt = ST_FAIL;
        end else if (bus.pc == bus.ER_max) begin
          state_nxt = ST_DONE;
        end else if (out_of_range) begin
          state_nxt = ST_FAIL;
        end
      end
      ST_DONE: begin
        if (!bus.exec_in) begin
          state_nxt = ST_FAIL;
        end else if (entry_ok) begin
          state_nxt = ST_RUN;
          cnt_clr   = 1'b1;
        end
      end
      default: begin
        if (entry_ok) begin
          state_nxt = ST_RUN;
          cnt_clr   = 1'b1;
        end
      end
    endcase
  end

  // State and result flags, registered together so the flags track the state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      er_done_q  <= 1'b0;
      er_abort_q <= 1'b0;
    end else begin
      state      <= state_nxt;
      er_done_q  <= (state_nxt == ST_DONE);
      er_abort_q <= (state_nxt == ST_FAIL);
    end
  end

  vape_sat_cnt #(
    .DATA_W (ADDR_W)
  ) u_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (cnt_clr),
    .en      (cnt_en),
    .cnt     (cnt)
  );

  assign bus.er_done  = er_done_q;
  assign bus.er_abort = er_abort_q;
  assign bus.exec_cnt = cnt;

endmodule

// File: tb/tb_vape_er_exit.sv
// Bench for vape_er_exit: directed scenarios plus randomized traffic, with a
// behavioural model feeding a scoreboard queue that a separate monitor drains.
module tb_vape_er_exit;
  import vape_pkg::*;

  logic clk;
  logic reset_n;

  vape_er_exit_if bus ();

  vape_er_exit dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        done;
    logic        abort;
    logic [15:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  // Behavioural model: a run is either in progress or has a recorded outcome.
  bit running;
  int outcome;   // 0 = none, 1 = legal exit, 2 = invalidated
  int m_cnt;

`ifdef VAPE_IRQ_ABORT_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif

  task automatic model_reset();
    running = 1'b0;
    outcome = 0;
    m_cnt   = 0;
  endtask

  task automatic model_step(input int pc, input bit irq, input bit ex,
                            input int lo, input int hi);
    bit entry;
    entry = ex && (pc == lo) && (lo <= hi);
    if (running) begin
      m_cnt = (m_cnt >= 65535) ? 65535 : m_cnt + 1;
      if (!ex || (IRQ_EN && irq)) begin
        running = 1'b0; outcome = 2;
      end else if (pc == hi) begin
        running = 1'b0; outcome = 1;
      end else if (pc < lo || pc > hi) begin
        running = 1'b0; outcome = 2;
      end
    end else if (outcome == 1 && !ex) begin
      outcome = 2;
    end else if (entry) begin
      running = 1'b1; outcome = 0; m_cnt = 0;
    end
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  // Drive one cycle of inputs, then queue what the model says follows the edge.
  task automatic step(input logic [15:0] pc, input bit irq, input bit ex);
    exp_t e;
    bus.pc      = pc;
    bus.irq     = irq;
    bus.exec_in = ex;
    model_step(int'(pc), irq, ex, int'(bus.ER_min), int'(bus.ER_max));
    @(posedge clk);
    e.done  = (!running && outcome == 1);
    e.abort = (!running && outcome == 2);
    e.cnt   = m_cnt[15:0];
    exp_q.push_back(e);
    #2;
  endtask

  // Monitor: compare DUT outputs against the oldest queued expectation.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("sb_done",  {15'd0, bus.er_done},  {15'd0, e.done});
      check("sb_abort", {15'd0, bus.er_abort}, {15'd0, e.abort});
      check("sb_cnt",   bus.exec_cnt,          e.cnt);
    end
  end

  task automatic drain();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    drain();
    reset_n = 1'b0;
    #1;
    model_reset();
    check("rst_done",  {15'd0, bus.er_done},  16'd0);
    check("rst_abort", {15'd0, bus.er_abort}, 16'd0);
    check("rst_cnt",   bus.exec_cnt,          16'd0);
    repeat (2) @(posedge clk);
    #3;
    reset_n = 1'b1;
    #2;
  endtask

  initial begin
    logic [15:0] p;
    int          sel;
    reset_n     = 1'b1;
    bus.pc      = 16'h0000;
    bus.irq     = 1'b0;
    bus.exec_in = 1'b0;
    bus.ER_min  = 16'hE000;
    bus.ER_max  = 16'hE0FE;
    model_reset();
    #3;
    do_reset();

    // Legal run: entry, one in-range step, exit at ER_max.
    step(16'h1234, 1'b0, 1'b1);
    step(16'hE000, 1'b0, 1'b1);
    step(16'hE002, 1'b0, 1'b1);
    step(16'hE0FE, 1'b0, 1'b1);
    drain();
    check("legal_done",  {15'd0, bus.er_done},  16'd1);
    check("legal_abort", {15'd0, bus.er_abort}, 16'd0);
    check("legal_cnt",   bus.exec_cnt,          16'd2);

    // Jump out of the region mid-run, then a few idle cycles (count frozen).
    step(16'hE000, 1'b0, 1'b1);
    step(16'hE010, 1'b0, 1'b1);
    step(16'hC000, 1'b0, 1'b1);
    step(16'hC004, 1'b0, 1'b1);
    step(16'hE020, 1'b0, 1'b1);
    drain();
    check("jump_abort", {15'd0, bus.er_abort}, 16'd1);
    check("jump_cnt",   bus.exec_cnt,          16'd2);

    // exec_in drops on the same cycle pc reaches ER_max.
    step(16'hE000, 1'b0, 1'b1);
    step(16'hE001, 1'b0, 1'b1);
    step(16'hE0FE, 1'b0, 1'b0);
    drain();
    check("tie_abort", {15'd0, bus.er_abort}, 16'd1);
    check("tie_done",  {15'd0, bus.er_done},  16'd0);

    // Interrupt inside the run.
    step(16'hE000, 1'b0, 1'b1);
    step(16'hE004, 1'b1, 1'b1);
    step(16'hE0FE, 1'b0, 1'b1);
    drain();
    check("irq_abort", {15'd0, bus.er_abort}, {15'd0, IRQ_EN});
    check("irq_done",  {15'd0, bus.er_done},  {15'd0, !IRQ_EN});

    // Loop back to ER_min inside the run, legal exit, META drop after DONE, re-entry.
    step(16'hE000, 1'b0, 1'b1);
    step(16'hE000, 1'b0, 1'b1);
    step(16'hE0FE, 1'b0, 1'b1);
    step(16'hE0FE, 1'b0, 1'b0);
    drain();
    check("done_drop_abort", {15'd0, bus.er_abort}, 16'd1);
    step(16'hE000, 1'b0, 1'b1);
    drain();
    check("reenter_cnt",   bus.exec_cnt,          16'd0);
    check("reenter_abort", {15'd0, bus.er_abort}, 16'd0);
    step(16'hE0FE, 1'b0, 1'b1);

    // Inverted region: entry must be refused.
    bus.ER_min = 16'hE100;
    bus.ER_max = 16'hE0FF;
    step(16'hE100, 1'b0, 1'b1);
    step(16'hE100, 1'b0, 1'b1);
    step(16'hE0FF, 1'b0, 1'b1);
    drain();
    check("inv_done", {15'd0, bus.er_done}, 16'd1);
    bus.ER_min = 16'hE000;
    bus.ER_max = 16'hE0FE;

    // Randomized traffic around the region.
    for (int i = 0; i < 3000; i++) begin
      sel = $urandom_range(0, 9);
      case (sel)
        0, 1:    p = 16'hE000;
        2:       p = 16'hE0FE;
        3:       p = 16'($urandom_range(0, 16'hDFFF));
        4:       p = 16'($urandom_range(16'hE0FF, 16'hFFFF));
        default: p = 16'($urandom_range(16'hE000, 16'hE0FE));
      endcase
      step(p, ($urandom_range(0, 19) == 0), ($urandom_range(0, 15) != 0));
    end

    // Long run to saturate the counter.
    step(16'hE0FE, 1'b0, 1'b0);
    step(16'hE000, 1'b0, 1'b1);
    for (int i = 0; i < 70000; i++) begin
      step(16'($urandom_range(16'hE001, 16'hE0FD)), 1'b0, 1'b1);
    end
    drain();
    check("sat_cnt", bus.exec_cnt, 16'hFFFF);

    // Reset mid-run discards it; re-entry needs a fresh entry at ER_min.
    do_reset();
    step(16'hE010, 1'b0, 1'b1);
    step(16'hE0FE, 1'b0, 1'b1);
    drain();
    check("post_rst_done", {15'd0, bus.er_done}, 16'd0);
    check("post_rst_cnt",  bus.exec_cnt,         16'd0);
    step(16'hE000, 1'b0, 1'b1);
    step(16'hE0FE, 1'b0, 1'b1);
    drain();
    check("post_rst_run", {15'd0, bus.er_done}, 16'd1);

    repeat (2) @(negedge clk);
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL sb_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
